// File: rtl/maze_pkg.sv
// Shared maze geometry, tile codes, neighbour directions and wall-sense FSM states.
// Also used by the Pac-Man wall logic through maze_tile_addr.
package maze_pkg;

  localparam int MAZE_W     = 28;
  localparam int MAZE_H     = 36;
  localparam int TUNNEL_ROW = 17;
  localparam int ROM_AW     = 10;

  localparam logic [2:0] TILE_EMPTY = 3'd0;
  localparam logic [2:0] TILE_DOT   = 3'd1;
  localparam logic [2:0] TILE_POWER = 3'd2;
  localparam logic [2:0] TILE_WALL  = 3'd3;
  localparam logic [2:0] TILE_DOOR  = 3'd4;

  typedef enum logic [1:0] {
    DIR_UP = 2'd0,
    DIR_DN = 2'd1,
    DIR_LF = 2'd2,
    DIR_RT = 2'd3
  } dir_e;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISS_UP = 3'd1,
    ISS_DN = 3'd2,
    ISS_LF = 3'd3,
    ISS_RT = 3'd4,
    CAP_RT = 3'd5
  } state_e;

  function automatic logic tile_blocked(input logic [2:0] code, input logic door_open);
    return (code == TILE_WALL) || ((code == TILE_DOOR) && !door_open);
  endfunction

endpackage

// File: rtl/maze_tile_addr.sv
// Neighbour tile address for one direction, with tunnel wrap and edge/out-of-range walls.
// Forced-wall neighbours report address 0 so the ROM read is harmless.
module maze_tile_addr
  import maze_pkg::*;
(
  input  logic [5:0]        x,
  input  logic [5:0]        y,
  input  dir_e              dir,
  output logic [ROM_AW-1:0] addr,
  output logic              forced_wall
);

  localparam logic [5:0] X_LAST = 6'(MAZE_W - 1);
  localparam logic [5:0] Y_LAST = 6'(MAZE_H - 1);
  localparam logic [5:0] X_LIM  = 6'(MAZE_W);
  localparam logic [5:0] Y_LIM  = 6'(MAZE_H);
  localparam logic [5:0] TUN_Y  = 6'(TUNNEL_ROW);

  logic [5:0]        nx;
  logic [5:0]        ny;
  logic [ROM_AW-1:0] ny_ext;

  always_comb begin
    nx          = x;
    ny          = y;
    forced_wall = 1'b0;
    case (dir)
      DIR_UP: if (y == 6'd0) forced_wall = 1'b1; else ny = y - 6'd1;
      DIR_DN: if (y == Y_LAST) forced_wall = 1'b1; else ny = y + 6'd1;
      DIR_LF: begin
        if (x == 6'd0) begin
          if (y == TUN_Y) nx = X_LAST;
          else            forced_wall = 1'b1;
        end else begin
          nx = x - 6'd1;
        end
      end
      DIR_RT: begin
        if (x == X_LAST) begin
          if (y == TUN_Y) nx = 6'd0;
          else            forced_wall = 1'b1;
        end else begin
          nx = x + 6'd1;
        end
      end
      default: forced_wall = 1'b1;
    endcase
    if ((x >= X_LIM) || (y >= Y_LIM)) forced_wall = 1'b1;
  end

  // ny*28 as shift-and-add keeps the address path multiplier-free
  assign ny_ext = ROM_AW'(ny);
  assign addr   = forced_wall ? '0
                : (ny_ext << 4) + (ny_ext << 3) + (ny_ext << 2) + ROM_AW'(nx);

endmodule

// File: rtl/maze_wall_sense.sv
// Ghost wall sensor: on a query, reads the four neighbour tiles from the maze ROM and
// returns registered wall flags with a one-cycle valid pulse at a fixed 5-edge latency.
module maze_wall_sense
  import maze_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              query,
  input  logic [5:0]        tileX,
  input  logic [5:0]        tileY,
  input  logic              door_open,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [2:0]        rom_data,
  output logic              wallUp,
  output logic              wallDown,
  output logic              wallLeft,
  output logic              wallRight,
  output logic              valid,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [5:0]        x_q, x_d;
  logic [5:0]        y_q, y_d;
  logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
  logic [2:0]        shadow_q, shadow_d;
  logic [3:0]        wall_q, wall_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;

  logic [5:0]        cur_x;
  logic [5:0]        cur_y;
  logic [ROM_AW-1:0] nb_addr [4];
  logic [3:0]        nb_forced;
  logic              rom_blocked;

  // The up address is issued on the accepting edge, before X/Y are latched
  assign cur_x = (state_q == IDLE) ? tileX : x_q;
  assign cur_y = (state_q == IDLE) ? tileY : y_q;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_nb
      localparam dir_e DIR = dir_e'(gi);
      maze_tile_addr u_addr (
        .x           (cur_x),
        .y           (cur_y),
        .dir         (DIR),
        .addr        (nb_addr[gi]),
        .forced_wall (nb_forced[gi])
      );
    end
  endgenerate

  assign rom_blocked = tile_blocked(rom_data, door_open);

  always_comb begin
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    rom_addr_d = rom_addr_q;
    shadow_d   = shadow_q;
    wall_d     = wall_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    case (state_q)
      IDLE: begin
        if (query) begin
          x_d        = tileX;
          y_d        = tileY;
          rom_addr_d = nb_addr[DIR_UP];
          busy_d     = 1'b1;
          state_d    = ISS_UP;
        end
      end
      ISS_UP: begin
        rom_addr_d = nb_addr[DIR_DN];
        state_d    = ISS_DN;
      end
      ISS_DN: begin
        rom_addr_d           = nb_addr[DIR_LF];
        shadow_d[DIR_UP]     = nb_forced[DIR_UP] | rom_blocked;
        state_d              = ISS_LF;
      end
      ISS_LF: begin
        rom_addr_d           = nb_addr[DIR_RT];
        shadow_d[DIR_DN]     = nb_forced[DIR_DN] | rom_blocked;
        state_d              = ISS_RT;
      end
      ISS_RT: begin
        shadow_d[DIR_LF]     = nb_forced[DIR_LF] | rom_blocked;
        state_d              = CAP_RT;
      end
      CAP_RT: begin
        wall_d  = {nb_forced[DIR_RT] | rom_blocked, shadow_q};
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      y_q        <= '0;
      rom_addr_q <= '0;
      shadow_q   <= '0;
      wall_q     <= 4'b1111;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rom_addr_q <= rom_addr_d;
      shadow_q   <= shadow_d;
      wall_q     <= wall_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  assign rom_addr  = rom_addr_q;
  assign wallUp    = wall_q[DIR_UP];
  assign wallDown  = wall_q[DIR_DN];
  assign wallLeft  = wall_q[DIR_LF];
  assign wallRight = wall_q[DIR_RT];
  assign valid     = valid_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_maze_wall_sense.sv
// Directed and randomised checks of maze_wall_sense against a behavioural 1-cycle tile ROM.
// Expected wall sets and valid cycles are queued at query time and checked on each valid pulse.
module tb_maze_wall_sense;

  logic       clk;
  logic       rst_n;
  logic       query;
  logic [5:0] tileX;
  logic [5:0] tileY;
  logic       door_open;
  logic [9:0] rom_addr;
  logic [2:0] rom_data;
  logic       wallUp, wallDown, wallLeft, wallRight;
  logic       valid;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    logic [3:0] walls;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  logic [2:0] rom_mem [0:1023];

  maze_wall_sense dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .query     (query),
    .tileX     (tileX),
    .tileY     (tileY),
    .door_open (door_open),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .wallUp    (wallUp),
    .wallDown  (wallDown),
    .wallLeft  (wallLeft),
    .wallRight (wallRight),
    .valid     (valid),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rom_data <= rom_mem[rom_addr];

  initial begin
    #(40 * 5000);
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] walls_now();
    return {wallRight, wallLeft, wallDown, wallUp};
  endfunction

  function automatic void set_tile(input int x, input int y, input logic [2:0] code);
    rom_mem[y * 28 + x] = code;
  endfunction

  // Reference: bit 0 up, 1 down, 2 left, 3 right
  function automatic logic [3:0] model(input int x, input int y, input logic door);
    logic [3:0] w;
    logic [2:0] code;
    int nx, ny;
    bit forced;
    for (int d = 0; d < 4; d++) begin
      forced = 0; nx = x; ny = y;
      case (d)
        0: if (y == 0) forced = 1; else ny = y - 1;
        1: if (y == 35) forced = 1; else ny = y + 1;
        2: if (x == 0) begin if (y == 17) nx = 27; else forced = 1; end else nx = x - 1;
        default: if (x == 27) begin if (y == 17) nx = 0; else forced = 1; end else nx = x + 1;
      endcase
      if (x >= 28 || y >= 36) forced = 1;
      if (forced) w[d] = 1'b1;
      else begin
        code = rom_mem[ny * 28 + nx];
        w[d] = (code == 3'd3) || (code == 3'd4 && !door);
      end
    end
    return w;
  endfunction

  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", {15'd0, valid}, 16'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        $display("valid at edge %0d: walls R/L/D/U=%b expected %b", cyc, walls_now(), e.walls);
        check("walls", {12'd0, walls_now()}, {12'd0, e.walls});
        check("latency_edge", 16'(cyc), 16'(e.cyc));
      end
    end
  end

  // Caller must be at a negedge; returns at the negedge after the accepting edge
  task automatic do_query(input int x, input int y, input logic door, input bit push,
                          input logic [3:0] exp_w, output int e);
    exp_t ent;
    door_open = door;
    query     = 1'b1;
    tileX     = 6'(x);
    tileY     = 6'(y);
    e         = cyc + 1;
    if (push) begin
      ent.walls = exp_w;
      ent.cyc   = e + 5;
      sb.push_back(ent);
    end
    $display("query (%0d,%0d) door=%0b accept edge %0d expect %b", x, y, door, e, exp_w);
    @(negedge clk);
    query = 1'b0;
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  task automatic wait_done();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    check("valid_timeout", 16'(sb.size()), 16'd0);
    sb.delete();
    @(negedge clk);
  endtask

  initial begin
    int e, e2;
    int rx, ry;
    logic rd;
    rst_n = 1'b0; query = 1'b0; tileX = '0; tileY = '0; door_open = 1'b0;
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'((i % 3));
    rom_mem[0] = 3'd3;

    repeat (3) @(negedge clk);
    check("rst_walls", {12'd0, walls_now()}, 16'hF);
    check("rst_valid", {15'd0, valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_addr", {6'd0, rom_addr}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: open corridor, only up is a wall
    set_tile(13, 13, 3'd3); set_tile(13, 15, 3'd0);
    set_tile(12, 14, 3'd1); set_tile(14, 14, 3'd2);
    do_query(13, 14, 1'b0, 1, 4'b0001, e);
    wait_done();
    repeat (3) @(negedge clk);
    check("walls_hold", {12'd0, walls_now()}, 16'h1);

    // 2: tunnel wrap on row 17, forced wall elsewhere (address 0 holds a wall code)
    set_tile(27, 17, 3'd0); set_tile(1, 17, 3'd0);
    set_tile(0, 16, 3'd0);  set_tile(0, 18, 3'd0);
    do_query(0, 17, 1'b0, 1, 4'b0000, e);
    wait_to(e + 2);
    check("tunnel_left_addr", {6'd0, rom_addr}, 16'd503);
    wait_done();
    set_tile(27, 5, 3'd0); set_tile(1, 5, 3'd0);
    set_tile(0, 4, 3'd0);  set_tile(0, 6, 3'd0);
    rom_mem[0] = 3'd0;
    do_query(0, 5, 1'b0, 1, 4'b0100, e);
    wait_done();

    // 3: door above, closed then open
    set_tile(5, 4, 3'd4); set_tile(5, 6, 3'd0);
    set_tile(4, 5, 3'd0); set_tile(6, 5, 3'd0);
    do_query(5, 5, 1'b0, 1, 4'b0001, e);
    wait_done();
    do_query(5, 5, 1'b1, 1, 4'b0000, e);
    wait_done();

    // 4: out of range, busy window
    do_query(30, 40, 1'b0, 1, 4'b1111, e);
    check("busy_after_accept", {15'd0, busy}, 16'd1);
    wait_to(e + 5);
    check("busy_at_valid", {15'd0, busy}, 16'd0);
    wait_done();

    // 5: query during busy is dropped
    do_query(13, 14, 1'b0, 1, 4'b0001, e);
    check("busy_edge1", {15'd0, busy}, 16'd1);
    query = 1'b1; tileX = 6'd5; tileY = 6'd5;
    @(negedge clk);
    query = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);

    // 6: reset mid-sequence, then back-to-back queries
    do_query(5, 5, 1'b1, 0, 4'b0000, e);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_walls", {12'd0, walls_now()}, 16'hF);
    check("midrst_busy", {15'd0, busy}, 16'd0);
    check("midrst_valid", {15'd0, valid}, 16'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("postrst_walls", {12'd0, walls_now()}, 16'hF);

    do_query(13, 14, 1'b1, 1, 4'b0001, e);
    wait_to(e + 5);
    do_query(5, 5, 1'b1, 1, 4'b0000, e2);
    check("b2b_accept_edge", 16'(e2), 16'(e + 6));
    wait_done();

    // Random maze and coordinates against the reference model
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'($urandom_range(0, 4));
    for (int i = 0; i < 14; i++) begin
      rx = $urandom_range(0, 29);
      ry = $urandom_range(0, 37);
      if (i == 0) begin rx = 0;  ry = 17; end
      if (i == 1) begin rx = 27; ry = 17; end
      if (i == 2) begin rx = 27; ry = 35; end
      rd = 1'($urandom_range(0, 1));
      do_query(rx, ry, rd, 1, model(rx, ry, rd), e);
      wait_done();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
